// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the serial subtractor: FSM state encoding,
// default geometry and the counter-width / parameter-legality helpers.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 1;
  localparam int DEF_N     = DEF_WIDTH / DEF_DIGIT;

  // Slice counter must be at least one bit even when a single slice covers the word.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit digit_ok(input int width, input int digit);
    return (digit > 0) && (width >= 2) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit subtract slice: {bout, d_s} = a_s - b_s - bin.
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_s,
  input  logic [DIGIT-1:0] b_s,
  input  logic             bin,
  output logic [DIGIT-1:0] d_s,
  output logic             bout
);

  logic [DIGIT:0] res;

  // One extra bit captures the borrow as the sign of the widened difference.
  assign res  = {1'b0, a_s} - {1'b0, b_s} - (DIGIT+1)'(bin);
  assign d_s  = res[DIGIT-1:0];
  assign bout = res[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - borr_in, DIGIT bits per clock LSB first, with
// valid/ready handshakes on both sides and registered result flags.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borr_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borr_out,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  generate
    if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_params
      $fatal(1, "serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt;
  logic             borr_r;
  logic [WIDTH-1:0] diff_nx;
  logic [DIGIT-1:0] a_s;
  logic [DIGIT-1:0] b_s;
  logic [DIGIT-1:0] d_s;
  logic             bout;
  int               base;

  always_comb begin
    base = int'(cnt) * DIGIT;
  end

  assign a_s = a_r[base +: DIGIT];
  assign b_s = b_r[base +: DIGIT];

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .a_s  (a_s),
    .b_s  (b_s),
    .bin  (borr_r),
    .d_s  (d_s),
    .bout (bout)
  );

  // Result word with the current slice merged in, so flags see the final MSB.
  always_comb begin
    diff_nx = diff;
    diff_nx[base +: DIGIT] = d_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borr_out  <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      cnt       <= '0;
      borr_r    <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b;
            borr_r   <= borr_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          diff   <= diff_nx;
          borr_r <= bout;
          if (cnt == CW'(N-1)) begin
            borr_out  <= bout;
            ovf       <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (diff_nx[WIDTH-1] ^ a_r[WIDTH-1]);
            zero      <= (diff_nx == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor for DIGIT=1 and DIGIT=4.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] ed;
    logic       eb;
    logic       eo;
    logic       ez;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst1, iv1, ir1, bi1, ov1, or1, bo1, vf1, z1;
  logic [7:0] a1, b1, d1;
  logic       rst4, iv4, ir4, bi4, ov4, or4, bo4, vf4, z4;
  logic [7:0] a4, b4, d4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .borr_in(bi1), .out_valid(ov1), .out_ready(or1), .diff(d1),
    .borr_out(bo1), .ovf(vf1), .zero(z1)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .borr_in(bi4), .out_valid(ov4), .out_ready(or4), .diff(d4),
    .borr_out(bo4), .ovf(vf4), .zero(z4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_op1(input vec_t v, input string nm);
    int cyc;
    @(negedge clk);
    chk({nm, " idle in_ready"}, 32'(ir1), 32'd1);
    a1 = v.a; b1 = v.b; bi1 = v.bin; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; a1 = ~v.a; b1 = 8'h5A; bi1 = ~v.bin;
    cyc = 0;
    while (!ov1 && cyc < 40) begin
      chk({nm, " busy in_ready"}, 32'(ir1), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'd8);
    chk({nm, " diff"}, 32'(d1), 32'(v.ed));
    chk({nm, " borr_out"}, 32'(bo1), 32'(v.eb));
    chk({nm, " ovf"}, 32'(vf1), 32'(v.eo));
    chk({nm, " zero"}, 32'(z1), 32'(v.ez));
    chk({nm, " done in_ready"}, 32'(ir1), 32'd0);
    @(negedge clk); or1 = 1'b1;
    @(posedge clk); #1; or1 = 1'b0;
    chk({nm, " out_valid drop"}, 32'(ov1), 32'd0);
    chk({nm, " ready again"}, 32'(ir1), 32'd1);
  endtask

  task automatic do_op4(input logic [7:0] a, input logic [7:0] b, input logic bin, input string nm);
    int cyc;
    logic [8:0] r;
    logic       eo;
    r  = {1'b0, a} - {1'b0, b} - 9'(bin);
    eo = (a[7] ^ b[7]) & (r[7] ^ a[7]);
    @(negedge clk);
    a4 = a; b4 = b; bi4 = bin; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = 8'hC3; b4 = ~b;
    cyc = 0;
    while (!ov4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'd2);
    chk({nm, " result"}, {20'd0, r[7:0], r[8], eo, (r[7:0] == 8'd0), 1'b0},
        {20'd0, d4, bo4, vf4, z4, 1'b0});
    @(negedge clk); or4 = 1'b1;
    @(posedge clk); #1; or4 = 1'b0;
    chk({nm, " idle"}, {30'd0, ir4, ov4}, 32'd2);
  endtask

  vec_t tbl[9];

  initial begin
    int cyc;
    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h33, 8'h33, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{8'h0A, 8'h04, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0};

    rst1 = 1'b1; iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; bi1 = 1'b0;
    rst4 = 1'b1; iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", {22'd0, ir1, ov1, d1, bo1, vf1, z1}, {22'd0, 1'b1, 1'b0, 8'h00, 3'b000});
    @(negedge clk); rst1 = 1'b0; rst4 = 1'b0;

    for (int i = 0; i < 9; i++) do_op1(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: result held for 5 cycles, input pulses ignored.
    @(negedge clk);
    a1 = 8'h05; b1 = 8'h03; bi1 = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1; iv1 = 1'b0;
    cyc = 0;
    while (!ov1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("bp latency", 32'(cyc), 32'd8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      iv1 = k[0]; a1 = 8'hEE; b1 = 8'h11;
      @(posedge clk); #1;
      chk("bp hold", {20'd0, ov1, ir1, d1, bo1, vf1}, {20'd0, 1'b1, 1'b0, 8'h02, 2'b00});
    end
    @(negedge clk); iv1 = 1'b0; or1 = 1'b1;
    @(posedge clk); #1; or1 = 1'b0;
    chk("bp release", {30'd0, ir1, ov1}, 32'd2);

    // Reset during the third BUSY cycle.
    @(negedge clk);
    a1 = 8'hC8; b1 = 8'h37; bi1 = 1'b1; iv1 = 1'b1;
    @(posedge clk); #1; iv1 = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst1 = 1'b1;
    @(posedge clk); #1;
    chk("mid reset", {20'd0, ir1, ov1, d1, bo1, vf1}, {20'd0, 1'b1, 1'b0, 8'h00, 2'b00});
    chk("mid reset zero", 32'(z1), 32'd0);
    @(negedge clk); rst1 = 1'b0;
    do_op1(tbl[8], "post reset");

    do_op4(8'h41, 8'h12, 1'b0, "d4 directed");
    chk("d4 diff 2F", 32'(d4), 32'h2F);
    for (int k = 0; k < 1000; k++) begin
      do_op4(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             $sformatf("d4 rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
